// File: rtl/rxmacfilter.sv
// Receive-side destination MAC filter: delays the byte stream by six strobes and lets a
// packet through only if it is addressed to us, broadcast, multicast (optional) or promiscuous.
module rxmacfilter #(
  parameter logic OPT_MULTICAST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_en,
  input  logic [47:0] i_hw_mac,
  input  logic        i_v,
  input  logic [7:0]  i_byte,
  output logic        o_v,
  output logic [7:0]  o_byte,
  output logic        o_bcast,
  output logic        o_mcast,
  output logic        o_match,
  output logic        o_drop
);

  typedef enum logic [2:0] {IDLE, ADDR, PASS, REJECT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             synced, en_l, accept, mute;
  logic             eq_r, ff_r, mc_r;
  logic             eq_n, ff_n, mc_n, ok;
  logic             v_in, v_shift, take, drop_set;
  logic [2:0]       pos;
  logic [47:0]      r_hw;
  logic [7:0]       hw_byte;
  logic [5:0]       dv;
  logic [5:0][7:0]  db;

  // A packet that starts before the line has drained is muted so it never reaches o_v.
  assign v_in    = i_v & synced;
  assign v_shift = v_in & ~mute & (state != DRAIN);
  assign o_v     = dv[5] & accept;
  assign o_byte  = db[5];

  always_comb begin
    case (pos)
      3'd0:    hw_byte = r_hw[47:40];
      3'd1:    hw_byte = r_hw[39:32];
      3'd2:    hw_byte = r_hw[31:24];
      3'd3:    hw_byte = r_hw[23:16];
      3'd4:    hw_byte = r_hw[15:8];
      3'd5:    hw_byte = r_hw[7:0];
      default: hw_byte = 8'h00;
    endcase
  end

  always_comb begin
    eq_n = ((pos == 3'd0) ? 1'b1 : eq_r) & (i_byte == hw_byte);
    ff_n = ((pos == 3'd0) ? 1'b1 : ff_r) & (i_byte == 8'hff);
    mc_n = (pos == 3'd0) ? i_byte[0] : mc_r;
    ok   = ~en_l | eq_n | ff_n | (OPT_MULTICAST & mc_n);
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    drop_set  = 1'b0;
    case (state)
      IDLE: if (v_in) state_nxt = ADDR;
      ADDR: begin
        if (!v_in) begin
          state_nxt = DRAIN;
          drop_set  = 1'b1;
        end else if (pos == 3'd5) begin
          take      = 1'b1;
          drop_set  = ~ok;
          state_nxt = ok ? PASS : REJECT;
        end
      end
      PASS, REJECT: if (!v_in) state_nxt = DRAIN;
      DRAIN: begin
        if (v_in) begin
          state_nxt = REJECT;
          drop_set  = 1'b1;
        end else if (!dv[4]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)   state <= IDLE;
    else if (i_ce) state <= state_nxt;
  end

  // Decision and flags clear once the last valid byte has left the final stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      synced  <= 1'b0;
      mute    <= 1'b0;
      dv      <= '0;
      db      <= '0;
      pos     <= 3'd0;
      r_hw    <= i_hw_mac;
      en_l    <= i_en;
      eq_r    <= 1'b0;
      ff_r    <= 1'b0;
      mc_r    <= 1'b0;
      accept  <= 1'b0;
      o_match <= 1'b0;
      o_bcast <= 1'b0;
      o_mcast <= 1'b0;
      o_drop  <= 1'b0;
    end else if (i_ce) begin
      if (!i_v) begin
        synced <= 1'b1;
        r_hw   <= i_hw_mac;
        en_l   <= i_en;
      end
      dv <= {dv[4:0], v_shift};
      db <= {db[4:0], i_byte};
      if (!v_in)              pos <= 3'd0;
      else if (pos != 3'd6)   pos <= pos + 3'd1;
      eq_r <= eq_n;
      ff_r <= ff_n;
      mc_r <= mc_n;
      if (!v_in)               mute <= 1'b0;
      else if (state == DRAIN) mute <= 1'b1;
      o_drop <= drop_set;
      if (take) begin
        accept  <= ok;
        o_match <= ok & eq_n;
        o_bcast <= ok & ff_n;
        o_mcast <= ok & mc_n & ~ff_n;
      end else if (!dv[4]) begin
        accept  <= 1'b0;
        o_match <= 1'b0;
        o_bcast <= 1'b0;
        o_mcast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rxmacfilter.sv
// Bench for rxmacfilter: two instances (multicast accepted / rejected) checked every strobe
// against a packet-level prediction, plus hand-computed spot checks per scenario.
module tb_rxmacfilter;

  localparam logic [47:0] MAC = 48'h02000a0b0c0d;
  localparam int NS = 1024;

  logic        clk = 1'b0;
  logic        i_reset, i_ce, i_en, i_v;
  logic [47:0] i_hw_mac;
  logic [7:0]  i_byte;
  logic        ov[2];
  logic [7:0]  ob[2];
  logic        obc[2], omc[2], omt[2], odr[2];

  rxmacfilter #(.OPT_MULTICAST(1'b1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en), .i_hw_mac(i_hw_mac),
    .i_v(i_v), .i_byte(i_byte), .o_v(ov[0]), .o_byte(ob[0]), .o_bcast(obc[0]),
    .o_mcast(omc[0]), .o_match(omt[0]), .o_drop(odr[0]));

  rxmacfilter #(.OPT_MULTICAST(1'b0)) dut_nomc (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en), .i_hw_mac(i_hw_mac),
    .i_v(i_v), .i_byte(i_byte), .o_v(ov[1]), .o_byte(ob[1]), .o_bcast(obc[1]),
    .o_mcast(omc[1]), .o_match(omt[1]), .o_drop(odr[1]));

  always #5 clk = ~clk;

  // Expected outputs per strobe slot, filled when a packet starts.
  bit         ev[2][NS];
  logic [7:0] eb[2][NS];
  bit         em[2][NS], ebc[2][NS], emc[2][NS], ed[2][NS];

  int slot = 0;
  int checks = 0;
  int passed = 0;
  int ce_div = 1;
  bit checking = 1'b0;
  int n_out[2], n_drop[2], first_v[2], drop_at[2];
  bit seen_match[2], seen_bcast[2], seen_mcast[2];

  always @(posedge clk) if (i_ce && !i_reset) slot <= slot + 1;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s (slot %0d): got %0h, expected %0h", name, slot, act, exp);
  endtask

  function automatic logic [7:0] pkt_byte(input logic [47:0] dest, input int k);
    if (k < 6) return 8'(dest >> (8 * (5 - k)));
    return 8'(k * 37 + 11);
  endfunction

  function automatic bit model_accept(input logic [47:0] dest, input logic [47:0] mac,
                                      input bit en, input bit opt);
    return !en || dest == mac || dest == 48'hffffffffffff || (opt && dest[40]);
  endfunction

  task automatic predict(input logic [47:0] dest, input int len, input int s);
    bit acc, bc;
    for (int i = 0; i < 2; i++) begin
      acc = (len >= 6) && model_accept(dest, i_hw_mac, i_en, i == 0);
      bc  = (dest == 48'hffffffffffff);
      if (acc) begin
        for (int k = 0; k < len; k++) begin
          ev[i][s+6+k]  = 1'b1;
          eb[i][s+6+k]  = pkt_byte(dest, k);
          em[i][s+6+k]  = (dest == i_hw_mac);
          ebc[i][s+6+k] = bc;
          emc[i][s+6+k] = dest[40] && !bc;
        end
      end else begin
        ed[i][(len >= 6) ? s + 6 : s + len + 1] = 1'b1;
      end
    end
  endtask

  // Per-strobe comparison against the prediction, plus counters for the spot checks.
  always @(negedge clk) begin
    if (checking && i_ce && !i_reset) begin
      if (slot >= NS - 80) check_output("slot_budget", 8'(slot >> 4), 8'((NS - 80) >> 4));
      else begin
        for (int i = 0; i < 2; i++) begin
          check_output($sformatf("o_v[%0d]", i), 8'(ov[i]), 8'(ev[i][slot]));
          check_output($sformatf("o_drop[%0d]", i), 8'(odr[i]), 8'(ed[i][slot]));
          if (ev[i][slot]) begin
            check_output($sformatf("o_byte[%0d]", i), ob[i], eb[i][slot]);
            check_output($sformatf("o_match[%0d]", i), 8'(omt[i]), 8'(em[i][slot]));
            check_output($sformatf("o_bcast[%0d]", i), 8'(obc[i]), 8'(ebc[i][slot]));
            check_output($sformatf("o_mcast[%0d]", i), 8'(omc[i]), 8'(emc[i][slot]));
          end
          if (ov[i]) begin
            n_out[i]++;
            if (first_v[i] < 0) first_v[i] = slot;
            seen_match[i] |= omt[i];
            seen_bcast[i] |= obc[i];
            seen_mcast[i] |= omc[i];
          end
          if (odr[i]) begin
            n_drop[i]++;
            drop_at[i] = slot;
          end
        end
      end
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      n_out[i] = 0; n_drop[i] = 0; first_v[i] = -1; drop_at[i] = -1;
      seen_match[i] = 0; seen_bcast[i] = 0; seen_mcast[i] = 0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    repeat (ce_div - 1) begin
      @(posedge clk); #1;
      i_ce = 1'b0;
    end
    @(posedge clk); #1;
    i_ce = 1'b1; i_v = v; i_byte = b;
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    check_output("o_v before reset", 8'(ov[0]), 8'h01);
    i_reset = 1'b1; i_ce = 1'b0;
    for (int j = slot; j < NS; j++)
      for (int i = 0; i < 2; i++) begin
        ev[i][j] = 0; ed[i][j] = 0;
      end
    @(posedge clk); #1;
    check_output("o_v after reset", 8'(ov[0]), 8'h00);
    check_output("o_byte after reset", ob[0], 8'h00);
    i_reset = 1'b0;
  endtask

  task automatic send_packet(input logic [47:0] dest, input int len, input int cut_at,
                             output int s);
    s = 0;
    for (int k = 0; k < len; k++) begin
      step(1'b1, pkt_byte(dest, k));
      if (k == 0) begin
        s = slot;
        predict(dest, len, s);
      end
      if (k == cut_at) mid_reset();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, s2;
    i_reset = 1'b1; i_ce = 1'b1; i_en = 1'b1; i_v = 1'b0; i_byte = 8'h00; i_hw_mac = MAC;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output("reset o_v", 8'(ov[i]), 8'h00);
      check_output("reset o_byte", ob[i], 8'h00);
      check_output("reset o_match", 8'(omt[i]), 8'h00);
      check_output("reset o_bcast", 8'(obc[i]), 8'h00);
      check_output("reset o_mcast", 8'(omc[i]), 8'h00);
      check_output("reset o_drop", 8'(odr[i]), 8'h00);
    end
    i_reset = 1'b0;
    checking = 1'b1;
    gap(8);

    // Unicast to us
    clear_mon();
    send_packet(MAC, 64, -1, s); gap(8);
    check_output("t1 count", 8'(n_out[0]), 8'd64);
    check_output("t1 count nomc", 8'(n_out[1]), 8'd64);
    check_output("t1 latency", 8'(first_v[0] - s), 8'd6);
    check_output("t1 match", 8'(seen_match[0]), 8'd1);
    check_output("t1 drops", 8'(n_drop[0]), 8'd0);

    // Broadcast
    clear_mon();
    send_packet(48'hffffffffffff, 24, -1, s); gap(8);
    check_output("t2 count", 8'(n_out[1]), 8'd24);
    check_output("t2 bcast", 8'(seen_bcast[0]), 8'd1);
    check_output("t2 mcast", 8'(seen_mcast[0]), 8'd0);

    // Other station
    clear_mon();
    send_packet(48'h02000a0b0c0e, 20, -1, s); gap(8);
    check_output("t3 count", 8'(n_out[0]), 8'd0);
    check_output("t3 drops", 8'(n_drop[0]), 8'd1);
    check_output("t3 drop slot", 8'(drop_at[0] - s), 8'd6);

    // Promiscuous
    i_en = 1'b0; gap(8);
    clear_mon();
    send_packet(48'h02000a0b0c0e, 20, -1, s); gap(8);
    check_output("t4 count", 8'(n_out[0]), 8'd20);
    check_output("t4 latency", 8'(first_v[0] - s), 8'd6);
    check_output("t4 match", 8'(seen_match[0]), 8'd0);
    i_en = 1'b1; gap(8);

    // Multicast: accepted only by the multicast-enabled instance
    clear_mon();
    send_packet(48'h01005e000001, 20, -1, s); gap(8);
    check_output("t4b count mc", 8'(n_out[0]), 8'd20);
    check_output("t4b mcast", 8'(seen_mcast[0]), 8'd1);
    check_output("t4b count nomc", 8'(n_out[1]), 8'd0);
    check_output("t4b drop nomc", 8'(n_drop[1]), 8'd1);

    // Runt followed by a good packet after the minimum gap
    clear_mon();
    send_packet(MAC, 4, -1, s); gap(6);
    send_packet(MAC, 16, -1, s2); gap(8);
    check_output("t5 drops", 8'(n_drop[0]), 8'd1);
    check_output("t5 drop slot", 8'(drop_at[0] - s), 8'd5);
    check_output("t5 count", 8'(n_out[0]), 8'd16);
    check_output("t5 latency", 8'(first_v[0] - s2), 8'd6);

    // Slow strobe with reset in the middle of a passing packet
    ce_div = 3;
    gap(8);
    send_packet(MAC, 40, 20, s); gap(8);
    clear_mon();
    send_packet(MAC, 30, -1, s2); gap(8);
    check_output("t6 count", 8'(n_out[0]), 8'd30);
    check_output("t6 latency", 8'(first_v[0] - s2), 8'd6);
    check_output("t6 match", 8'(seen_match[0]), 8'd1);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
